// File: rtl/usb_hub_port_scheduler_pkg.sv
// Shared types and helpers for the hub port scheduler.
// Holds the state encoding and the index-width helper.
package usb_hub_port_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_GRANT = 2'd1,
    SCHED_GUARD = 2'd2
  } sched_state_t;

  // Index width for n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_hub_port_scheduler_rr_arbiter.sv
// Rotating-pointer first-set-bit search.
// Searches from ptr+1 upward, wrapping modulo N.
module usb_hub_port_scheduler_rr_arbiter
  import usb_hub_port_scheduler_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic [N-1:0]  onehot,
  output logic          any_req
);

  logic [IW:0]    start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             s;

  // Rotate the request vector so bit 0 is the slot after ptr.
  always_comb begin
    start   = {1'b0, ptr} + (IW+1)'(1);
    dbl     = {req, req} >> start;
    rot     = dbl[N-1:0];
    any_req = |req;
    s       = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) s = int'(start) + j;
    end
    if (s >= N) s = s - N;
    sel    = IW'(s);
    onehot = any_req ? (N'(1) << sel) : '0;
  end

endmodule

// File: rtl/usb_hub_port_scheduler.sv
// Round-robin owner of the upstream link.
// One packet per grant, then a turnaround gap.
module usb_hub_port_scheduler
  import usb_hub_port_scheduler_pkg::*;
#(
  parameter  int NUM_USB_DEVICES = 2,
  parameter  int TIMEOUT_CYCLES  = 64,
  parameter  int GUARD_CYCLES    = 2,
  localparam int IW = idx_w(NUM_USB_DEVICES)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_USB_DEVICES-1:0] port_enable,
  input  logic [NUM_USB_DEVICES-1:0] port_req,
  input  logic [NUM_USB_DEVICES-1:0] port_val,
  input  logic [NUM_USB_DEVICES-1:0] port_last,
  input  logic                       link_ready,
  output logic [NUM_USB_DEVICES-1:0] grant,
  output logic [IW-1:0]              grant_idx,
  output logic                       busy,
  output logic                       timeout_pulse,
  output logic                       abort_pulse
);

  localparam int N  = NUM_USB_DEVICES;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = idx_w(GUARD_CYCLES);

  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GD_LAST = GW'(GUARD_CYCLES - 1);

  // With no turnaround the release goes straight back to IDLE.
  localparam sched_state_t REL_STATE =
    (GUARD_CYCLES == 0) ? SCHED_IDLE : SCHED_GUARD;

  sched_state_t  state;
  logic [IW-1:0] rr_ptr;
  logic [WW-1:0] wdog;
  logic [GW-1:0] gcnt;
  logic          seen;

  logic [N-1:0]  eff;
  logic [IW-1:0] arb_sel;
  logic [N-1:0]  arb_hot;
  logic          arb_any;

  logic g_val, g_last, g_req, g_en;
  logic fin, tmo, abt, rel;

  assign eff = port_req & port_enable;

  usb_hub_port_scheduler_rr_arbiter #(
    .N (N)
  ) u_arb (
    .req     (eff),
    .ptr     (rr_ptr),
    .sel     (arb_sel),
    .onehot  (arb_hot),
    .any_req (arb_any)
  );

  // Release causes for the granted port, in priority order.
  always_comb begin
    g_val  = |(port_val & grant);
    g_last = |(port_val & port_last & grant);
    g_req  = |(port_req & grant);
    g_en   = |(port_enable & grant);
    fin    = g_last;
    tmo    = !g_val && (wdog == WD_LAST);
    abt    = !fin && !tmo &&
             (!g_en || (!g_req && !seen && !g_val));
    rel    = fin || tmo || abt;
  end

  // Scheduler FSM with registered grant and pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= SCHED_IDLE;
      grant         <= '0;
      grant_idx     <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      abort_pulse   <= 1'b0;
      rr_ptr        <= IW'(N - 1);
      wdog          <= '0;
      gcnt          <= '0;
      seen          <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      abort_pulse   <= 1'b0;
      unique case (state)
        SCHED_IDLE: begin
          if (link_ready && arb_any) begin
            grant     <= arb_hot;
            grant_idx <= arb_sel;
            busy      <= 1'b1;
            rr_ptr    <= arb_sel;
            wdog      <= '0;
            seen      <= 1'b0;
            state     <= SCHED_GRANT;
          end
        end
        SCHED_GRANT: begin
          if (rel) begin
            grant         <= '0;
            busy          <= 1'b0;
            gcnt          <= '0;
            timeout_pulse <= tmo;
            abort_pulse   <= abt;
            state         <= REL_STATE;
          end else if (g_val) begin
            wdog <= '0;
            seen <= 1'b1;
          end else if (wdog != '1) begin
            wdog <= wdog + WW'(1);
          end
        end
        SCHED_GUARD: begin
          if (gcnt == GD_LAST) begin
            state <= SCHED_IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

  // Structural invariants of the grant outputs.
  a_onehot: assert property (
    @(posedge clock) disable iff (reset) $onehot0(grant));
  a_busy: assert property (
    @(posedge clock) disable iff (reset) busy == (|grant));
  a_pulse: assert property (
    @(posedge clock) disable iff (reset)
    !(timeout_pulse && abort_pulse));

endmodule

// File: tb/tb_usb_hub_port_scheduler.sv
// Directed bench for the hub port scheduler.
// Two ports, 64-cycle watchdog, 2-cycle guard.
module tb_usb_hub_port_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] port_enable = '0;
  logic [1:0] port_req = '0;
  logic [1:0] port_val = '0;
  logic [1:0] port_last = '0;
  logic       link_ready = 1'b0;
  logic [1:0] grant;
  logic [0:0] grant_idx;
  logic       busy;
  logic       timeout_pulse;
  logic       abort_pulse;

  int nerr = 0;
  int nchk = 0;

  usb_hub_port_scheduler #(
    .NUM_USB_DEVICES (2),
    .TIMEOUT_CYCLES  (64),
    .GUARD_CYCLES    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .port_enable   (port_enable),
    .port_req      (port_req),
    .port_val      (port_val),
    .port_last     (port_last),
    .link_ready    (link_ready),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .abort_pulse   (abort_pulse)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag,
                            input logic [1:0] g,
                            input logic b,
                            input logic tp,
                            input logic ap);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".tmo"}, 32'(timeout_pulse), 32'(tp));
    chk({tag, ".abt"}, 32'(abort_pulse), 32'(ap));
    if (b) chk({tag, ".idx"}, 32'(grant_idx), 32'(g == 2'b10));
  endtask

  task automatic packet(input int p, input int n);
    logic [1:0] own;
    logic [1:0] other;
    own   = 2'(1 << p);
    other = 2'(1 << (1 - p));
    for (int b = 1; b <= n; b++) begin
      port_val  = 2'b11;
      port_last = (b == n) ? own : other;
      tick;
      if (b < n) expect_out("pkt", own, 1'b1, 1'b0, 1'b0);
      else       expect_out("pkt_end", 2'b00, 1'b0, 1'b0, 1'b0);
    end
    port_val  = '0;
    port_last = '0;
  endtask

  task automatic guard_then(input string tag, input logic [1:0] g);
    tick;
    expect_out("guard1", 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    expect_out("guard2", 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    expect_out(tag, g, g != 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    #12;
    expect_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    reset       = 1'b0;
    port_enable = 2'b11;
    port_req    = 2'b01;
    link_ready  = 1'b1;
    tick;
    expect_out("first", 2'b01, 1'b1, 1'b0, 1'b0);

    port_req = 2'b00;
    packet(0, 10);
    port_req = 2'b01;
    guard_then("regrant0", 2'b01);

    port_req = 2'b00;
    tick;
    expect_out("abort", 2'b00, 1'b0, 1'b0, 1'b1);
    port_req = 2'b11;
    guard_then("rr1", 2'b10);
    packet(1, 4);
    guard_then("rr0", 2'b01);
    packet(0, 4);
    guard_then("rr1b", 2'b10);
    packet(1, 4);
    guard_then("rr0b", 2'b01);
    packet(0, 4);
    guard_then("rr1c", 2'b10);

    for (int k = 1; k <= 63; k++) begin
      tick;
      expect_out("wd", 2'b10, 1'b1, 1'b0, 1'b0);
    end
    tick;
    expect_out("timeout", 2'b00, 1'b0, 1'b1, 1'b0);
    guard_then("after_tmo", 2'b01);

    port_enable = 2'b10;
    tick;
    expect_out("dis_abort", 2'b00, 1'b0, 1'b0, 1'b1);
    guard_then("dis1", 2'b10);
    packet(1, 4);
    guard_then("dis1b", 2'b10);
    packet(1, 4);

    link_ready  = 1'b0;
    port_enable = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick;
      expect_out("nolink", 2'b00, 1'b0, 1'b0, 1'b0);
    end
    link_ready = 1'b1;
    tick;
    expect_out("link", 2'b01, 1'b1, 1'b0, 1'b0);

    for (int b = 1; b <= 4; b++) begin
      port_val = 2'b01;
      tick;
      expect_out("mid", 2'b01, 1'b1, 1'b0, 1'b0);
    end
    port_val = 2'b01;
    #3;
    reset = 1'b1;
    #1;
    expect_out("mid_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    port_val = 2'b00;
    tick;
    reset = 1'b0;
    tick;
    expect_out("post_rst", 2'b01, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/usb_hub_port_scheduler.md
Name: usb_hub_port_scheduler

Overview:
- Round-robin scheduler that shares the single upstream host link between NUM_USB_DEVICES downstream port datapaths (per-port fifo -> piso -> trans-receiver chain).
- Grants one port at a time for exactly one packet, and releases the grant on the packet's last bit, on a watchdog timeout or on request withdrawal.
- Enforces a bus turnaround gap between consecutive packets. Sits in usb_hub_top between the per-port datapaths and the upstream link.

Parameters:
- NUM_USB_DEVICES, 2: number of downstream ports; minimum 1.
- TIMEOUT_CYCLES, 64: max idle cycles (no port_val) while granted before forced release; minimum 2.
- GUARD_CYCLES, 2: turnaround cycles between releasing one grant and issuing the next; 0 is legal.

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- port_enable  input  NUM_USB_DEVICES  port attached/enabled; a disabled port is never granted.
- port_req  input  NUM_USB_DEVICES  port has a packet to send; level, held until granted or withdrawn.
- port_val  input  NUM_USB_DEVICES  port is driving a serial bit this cycle.
- port_last  input  NUM_USB_DEVICES  final bit of the packet; qualified by port_val.
- link_ready  input  1  upstream link can accept a new packet.
- grant  output  NUM_USB_DEVICES  one-hot grant, registered.
- grant_idx  output  $clog2(NUM_USB_DEVICES) (min 1)  index of the granted port; valid while busy.
- busy  output  1  a grant is active.
- timeout_pulse  output  1  one-cycle pulse on watchdog release.
- abort_pulse  output  1  one-cycle pulse when the granted port drops port_req before its first port_val.

Behaviour:
- Reset values: grant=0, grant_idx=0, busy=0, timeout_pulse=0, abort_pulse=0, state=IDLE. Internal: rr_ptr=NUM_USB_DEVICES-1, so port 0 has first priority; counters=0.
- Reset is async assert; all outputs clear immediately, including mid-packet.
- Effective request: eff = port_req & port_enable.
- State IDLE:
  - If link_ready and eff!=0: select the first set bit of eff searching from rr_ptr+1, wrapping modulo NUM_USB_DEVICES.
  - Next cycle: grant=onehot(sel), grant_idx=sel, busy=1, rr_ptr=sel, state=GRANT. Grant latency is exactly 1 cycle.
  - Otherwise stay in IDLE.
- State GRANT:
  - Priority 1, port_val[g] & port_last[g] for the granted port g: next cycle grant=0, busy=0, state=GUARD.
  - Priority 2, watchdog reaches TIMEOUT_CYCLES-1 with no port_val[g]: timeout_pulse=1 for one cycle, grant released, state=GUARD.
  - Priority 3, port_req[g]=0 and no port_val[g] seen since the grant: abort_pulse=1, grant released, state=GUARD. Once the first port_val has been seen, dropping port_req is ignored.
  - Watchdog: clears on grant and on every port_val[g]; otherwise increments. Width $clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
  - port_val/port_last from non-granted ports are ignored.
  - port_enable[g] deasserting mid-grant is treated as an abort: abort_pulse=1, release.
  - link_ready is not sampled during GRANT.
- State GUARD:
  - Count GUARD_CYCLES cycles with grant=0, then go to IDLE.
  - If GUARD_CYCLES=0, pass straight through to IDLE, so the next grant follows 2 cycles after release.
- Invariants:
  - grant is zero or one-hot.
  - busy == |grant.
  - timeout_pulse and abort_pulse are never both high.
  - rr_ptr updates only on grant issue.
- Fairness: any continuously requesting enabled port is granted within NUM_USB_DEVICES grants.

Decomposition:
- Shared package/includes:
  - state encoding constants SCHED_IDLE/GRANT/GUARD.
  - width macro for grant_idx, reusing the `WIDTH_TO_RANGE style.
- Sub-module rr_arbiter (parameter N):
  - combinational first-set-bit search from a rotating pointer.
  - outputs sel index, one-hot and any_req.
  - reusable for future split-transaction scheduling.

Test Plan:
- Single request: reset released, port_req=2'b01, link_ready=1 -> grant=2'b01 one cycle later. Port sends 10 val bits with last on the 10th -> grant=0 the next cycle, then 2 guard cycles, then IDLE.
- Round-robin: port_req=2'b11 held, each packet 4 bits -> grant order 0,1,0,1. Each grant starts 1+GUARD_CYCLES+1 cycles after the previous last.
- Timeout: grant port 1 with port_val never asserted -> timeout_pulse at cycle 64 after grant, grant cleared, rr_ptr=1.
- Abort and disabled port:
  - Granted port drops port_req before any val -> abort_pulse=1, release.
  - With port_enable=2'b10 and port_req=2'b11 -> only port 1 is ever granted.
- Mid-packet reset: assert reset during bit 5 of a packet -> grant, busy and pulses are 0 in the same cycle. After release, port 0 has priority again.
- link_ready=0 with requests pending -> no grant. The cycle after link_ready=1, grant is issued to the rr-next port.
